// File: rtl/uart_tx_fsmd.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Every bit is held for 2^sampling_cntr_width clock cycles; Tx is registered.
module uart_tx_fsmd #(
  parameter int parity_on           = 1,
  parameter int parity_odd          = 0,
  parameter int data_size           = 8,
  parameter int sampling_cntr_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_valid,
  input  logic [data_size-1:0] data_in,
  output logic                 data_ready,
  output logic                 Tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BCW = (data_size > 1) ? $clog2(data_size) : 1;
  localparam logic [BCW-1:0]                 BIT_LAST = BCW'(data_size - 1);
  localparam logic [BCW-1:0]                 BIT_ONE  = BCW'(1);
  localparam logic [sampling_cntr_width-1:0] SMP_ONE  = sampling_cntr_width'(1);

  // state    | meaning
  // S_IDLE   | line high, data_ready=1, waiting for data_valid
  // S_START  | start bit (Tx=0)
  // S_DATA   | data bits, LSB first from shift register bit 0
  // S_PARITY | parity bit (only reachable when parity_on)
  // S_STOP   | stop bit (Tx=1), frame_done raised on exit
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [sampling_cntr_width-1:0] smp_cnt_q, smp_cnt_d;
  logic [BCW-1:0]                 bit_cnt_q, bit_cnt_d;
  logic [data_size-1:0]           shift_q, shift_d;
  logic                           parity_q, parity_d;
  logic                           tx_q, tx_d;
  logic                           done_q, done_d;
  logic                           bit_end;

  assign bit_end = (smp_cnt_q == '1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          state_d  = S_START;
          shift_d  = data_in;
          parity_d = (^data_in) ^ (parity_odd != 0);
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = (parity_on != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counter restarts on every state entry; inside DATA it wraps on its own.
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      smp_cnt_d = '0;
    end else begin
      smp_cnt_d = smp_cnt_q + SMP_ONE;
    end

    // Tx is registered, so it follows the state being entered, not the current one.
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      smp_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign data_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign Tx         = tx_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_fsmd.sv
// Self-checking bench for uart_tx_fsmd: four parameter sets, frames compared
// cycle by cycle against a bit-list model of the frame format.
module tb_uart_tx_fsmd;

  localparam int NCFG = 4;
  localparam int CFG_PON  [NCFG] = '{1, 1, 1, 0};
  localparam int CFG_PODD [NCFG] = '{0, 1, 0, 0};
  localparam int CFG_DS   [NCFG] = '{8, 8, 5, 8};
  localparam int CFG_W    [NCFG] = '{4, 4, 2, 4};

  logic            clk = 1'b0;
  logic            rst;
  logic [NCFG-1:0] valid_v;
  logic [NCFG-1:0] ready_v, tx_v, busy_v, done_v;
  logic [7:0]      d0_data, d1_data, d3_data;
  logic [4:0]      d2_data;

  always #5 clk = ~clk;

  uart_tx_fsmd u_d0 (
    .clk(clk), .rst(rst), .data_valid(valid_v[0]), .data_in(d0_data),
    .data_ready(ready_v[0]), .Tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));
  uart_tx_fsmd #(.parity_odd(1)) u_d1 (
    .clk(clk), .rst(rst), .data_valid(valid_v[1]), .data_in(d1_data),
    .data_ready(ready_v[1]), .Tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));
  uart_tx_fsmd #(.data_size(5), .sampling_cntr_width(2)) u_d2 (
    .clk(clk), .rst(rst), .data_valid(valid_v[2]), .data_in(d2_data),
    .data_ready(ready_v[2]), .Tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));
  uart_tx_fsmd #(.parity_on(0)) u_d3 (
    .clk(clk), .rst(rst), .data_valid(valid_v[3]), .data_in(d3_data),
    .data_ready(ready_v[3]), .Tx(tx_v[3]), .busy(busy_v[3]), .frame_done(done_v[3]));

  int n_checks = 0;
  int n_errors = 0;

  logic exp_tx[$], exp_busy[$], exp_done[$];
  logic cap_tx[$], cap_busy[$], cap_done[$], cap_ready[$];

  typedef struct {
    int          sel;
    logic [15:0] word;
    int          exp_len;
    bit          has_par;
    logic        exp_par;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic add_vec(input int sel, input logic [15:0] word, input int len,
                         input bit has_par, input logic par, input string name);
    vec_t v;
    v.sel = sel; v.word = word; v.exp_len = len;
    v.has_par = has_par; v.exp_par = par; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic set_data(input int sel, input logic [15:0] w);
    case (sel)
      0:       d0_data = w[7:0];
      1:       d1_data = w[7:0];
      2:       d2_data = w[4:0];
      default: d3_data = w[7:0];
    endcase
  endtask

  task automatic clear_exp();
    exp_tx.delete(); exp_busy.delete(); exp_done.delete();
  endtask

  // Reference: list the frame's bit levels, then stretch each to one bit period.
  task automatic append_frame(input int sel, input logic [15:0] word);
    logic bits[$];
    logic par;
    int   per;
    per = 1 << CFG_W[sel];
    par = (CFG_PODD[sel] != 0);
    bits.push_back(1'b0);
    for (int i = 0; i < CFG_DS[sel]; i++) begin
      bits.push_back(word[i]);
      par = par ^ word[i];
    end
    if (CFG_PON[sel] != 0) bits.push_back(par);
    bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int j = 0; j < per; j++) begin
        exp_tx.push_back(bits[b]);
        exp_busy.push_back(1'b1);
        exp_done.push_back(1'b0);
      end
    end
  endtask

  task automatic append_gap(input logic d);
    exp_tx.push_back(1'b1);
    exp_busy.push_back(1'b0);
    exp_done.push_back(d);
  endtask

  task automatic capture(input int sel, input int n);
    cap_tx.delete(); cap_busy.delete(); cap_done.delete(); cap_ready.delete();
    for (int i = 0; i < n; i++) begin
      cap_tx.push_back(tx_v[sel]);
      cap_busy.push_back(busy_v[sel]);
      cap_done.push_back(done_v[sel]);
      cap_ready.push_back(ready_v[sel]);
      @(negedge clk);
    end
  endtask

  task automatic cmp_wave(input string name, input logic act[$], input logic expv[$]);
    int    bad;
    string detail;
    bad = -1;
    detail = "";
    for (int i = 0; i < expv.size(); i++) begin
      if (bad < 0 && (i >= act.size() || act[i] !== expv[i])) bad = i;
    end
    if (bad >= act.size())
      detail = $sformatf("only %0d samples, need %0d", act.size(), expv.size());
    else if (bad >= 0)
      detail = $sformatf("cycle %0d got %0b expected %0b", bad, act[bad], expv[bad]);
    check(bad < 0, name, detail);
  endtask

  task automatic compare_cap(input string prefix);
    logic exp_rdy[$];
    foreach (exp_busy[i]) exp_rdy.push_back(~exp_busy[i]);
    cmp_wave({prefix, "_tx"},    cap_tx,    exp_tx);
    cmp_wave({prefix, "_busy"},  cap_busy,  exp_busy);
    cmp_wave({prefix, "_done"},  cap_done,  exp_done);
    cmp_wave({prefix, "_ready"}, cap_ready, exp_rdy);
  endtask

  // Called at a negedge; the following posedge is the accepting edge k.
  task automatic do_frame(input int sel, input logic [15:0] word, input string name,
                          output int len, output logic par);
    int idx;
    check(ready_v[sel] === 1'b1, {name, "_ready_before"},
          $sformatf("got %0b expected 1", ready_v[sel]));
    set_data(sel, word);
    valid_v[sel] = 1'b1;
    @(negedge clk);
    valid_v[sel] = 1'b0;
    clear_exp();
    append_frame(sel, word);
    append_gap(1'b1);
    append_gap(1'b0);
    capture(sel, exp_tx.size());
    compare_cap(name);
    len = -1;
    foreach (cap_done[i]) if (len < 0 && cap_done[i] === 1'b1) len = i;
    idx = (1 + CFG_DS[sel]) * (1 << CFG_W[sel]) + (1 << CFG_W[sel]) / 2;
    par = (idx < cap_tx.size()) ? cap_tx[idx] : 1'bx;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int   len;
    logic par;
    int   run;

    add_vec(2, 16'h0013,  32, 1'b1, 1'b1, "ds5_13");
    add_vec(0, 16'h00A5, 176, 1'b1, 1'b0, "even_a5");
    add_vec(1, 16'h0007, 176, 1'b1, 1'b0, "odd_07");
    add_vec(3, 16'h0007, 160, 1'b0, 1'b0, "nopar_07");
    add_vec(0, 16'h00FF, 176, 1'b1, 1'b0, "even_ff");
    add_vec(1, 16'h0000, 176, 1'b1, 1'b1, "odd_00");

    rst = 1'b0;
    valid_v = '0;
    d0_data = '0; d1_data = '0; d2_data = '0; d3_data = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < NCFG; s++) begin
      check(tx_v[s] === 1'b1 && busy_v[s] === 1'b0 && ready_v[s] === 1'b1 && done_v[s] === 1'b0,
            $sformatf("reset_state_d%0d", s),
            $sformatf("got tx=%0b busy=%0b ready=%0b done=%0b expected 1 0 1 0",
                      tx_v[s], busy_v[s], ready_v[s], done_v[s]));
    end
    rst = 1'b1;

    // First table entry is accepted on the first edge after reset release.
    foreach (vecs[v]) begin
      do_frame(vecs[v].sel, vecs[v].word, vecs[v].name, len, par);
      check(len == vecs[v].exp_len, {vecs[v].name, "_frame_len"},
            $sformatf("got %0d expected %0d", len, vecs[v].exp_len));
      if (vecs[v].has_par)
        check(par === vecs[v].exp_par, {vecs[v].name, "_parity"},
              $sformatf("got %0b expected %0b", par, vecs[v].exp_par));
    end

    // data_in change and data_valid pulse mid-frame must be ignored.
    set_data(0, 16'h005A);
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    clear_exp();
    append_frame(0, 16'h005A);
    append_gap(1'b1);
    append_gap(1'b0);
    fork
      capture(0, exp_tx.size());
      begin
        repeat (40) @(negedge clk);
        set_data(0, 16'h00C3);
        valid_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        valid_v[0] = 1'b0;
      end
    join
    compare_cap("midframe");

    // data_valid held high: two back-to-back frames, one idle cycle between.
    set_data(0, 16'h0000);
    valid_v[0] = 1'b1;
    @(negedge clk);
    clear_exp();
    append_frame(0, 16'h0000);
    append_gap(1'b1);
    append_frame(0, 16'h00FF);
    append_gap(1'b1);
    append_gap(1'b0);
    fork
      capture(0, exp_tx.size());
      begin
        repeat (100) @(negedge clk);
        set_data(0, 16'h00FF);
        repeat (100) @(negedge clk);
        valid_v[0] = 1'b0;
      end
    join
    compare_cap("b2b");
    run = 0;
    for (int i = 176; i >= 0; i--) begin
      if (cap_tx[i] !== 1'b1) break;
      run++;
    end
    check(run == 17, "b2b_stop_run", $sformatf("got %0d expected 17", run));

    // Asynchronous reset fifty cycles into a frame.
    set_data(0, 16'h00C3);
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (50) @(negedge clk);
    check(busy_v[0] === 1'b1, "abort_busy_before", $sformatf("got %0b expected 1", busy_v[0]));
    #2 rst = 1'b0;
    #1;
    check(tx_v[0] === 1'b1 && busy_v[0] === 1'b0 && ready_v[0] === 1'b1 && done_v[0] === 1'b0,
          "abort_async",
          $sformatf("got tx=%0b busy=%0b ready=%0b done=%0b expected 1 0 1 0",
                    tx_v[0], busy_v[0], ready_v[0], done_v[0]));
    @(negedge clk);
    rst = 1'b1;
    clear_exp();
    for (int i = 0; i < 40; i++) append_gap(1'b0);
    capture(0, 40);
    compare_cap("after_abort");
    do_frame(0, 16'h003C, "post_abort_3c", len, par);
    check(len == 176, "post_abort_3c_len", $sformatf("got %0d expected 176", len));
    check(par === 1'b0, "post_abort_3c_parity", $sformatf("got %0b expected 0", par));

    // Random words on random configurations.
    for (int r = 0; r < 24; r++) begin
      int          sel;
      logic [15:0] w;
      sel = $urandom_range(0, NCFG - 1);
      w   = 16'($urandom);
      do_frame(sel, w, $sformatf("rand%0d_d%0d", r, sel), len, par);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
